// File: rtl/weight_mem_responder_if.sv
// Four-phase req/ack fetch bus between the controller (master) and a weight/pixel memory (slave).
// The err signal exists only when RESP_RANGE_CHECK_EN is defined.
interface weight_mem_responder_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 12
);
    logic              req;
    logic [ADDR_W-1:0] addr;
    logic              ack;
    logic [DATA_W-1:0] rdata;
    logic              busy;
`ifdef RESP_RANGE_CHECK_EN
    logic              err;

    modport master (output req, addr, input ack, rdata, busy, err);
    modport slave  (input req, addr, output ack, rdata, busy, err);
`else
    modport master (output req, addr, input ack, rdata, busy);
    modport slave  (input req, addr, output ack, rdata, busy);
`endif
endinterface

// File: rtl/weight_mem_responder.sv
// Memory responder: answers each four-phase fetch with the addressed word after LATENCY cycles.
// Optional feature macro: RESP_RANGE_CHECK_EN (addr >= DEPTH reads return 0 with err, writes dropped).
//
// state  | meaning
// S_IDLE | waiting for req; capture reads the array into the hold register
// S_WAIT | latency countdown, req ignored
// S_ACK  | ack raised for at least one cycle, held until req is seen low
module weight_mem_responder #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 12,
    parameter int DEPTH   = 196,
    parameter int LATENCY = 2
) (
    input  logic                       clk,
    input  logic                       rst_b,
    weight_mem_responder_if.slave      bus,
    input  logic                       wr_en,
    input  logic [ADDR_W-1:0]          wr_addr,
    input  logic [DATA_W-1:0]          wr_data
);
    localparam int MEM_WORDS = 2 ** ADDR_W;

    if (DEPTH < 1 || DEPTH > MEM_WORDS || LATENCY < 1 || LATENCY > 15) begin : g_bad_cfg
        $error("weight_mem_responder: illegal DEPTH or LATENCY");
    end

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_ACK  = 2'd2
    } state_t;

    state_t            r_state;
    logic [3:0]        r_cnt;
    logic              r_ack;
    logic              r_busy;
    logic [DATA_W-1:0] r_rdata;
    logic [DATA_W-1:0] r_mem [MEM_WORDS];

`ifdef RESP_RANGE_CHECK_EN
    logic r_err;
    logic w_rd_in_range;
    logic w_wr_in_range;

    // Compare one bit wider so DEPTH == 2**ADDR_W does not wrap to zero.
    assign w_rd_in_range = {1'b0, bus.addr} < (ADDR_W+1)'(DEPTH);
    assign w_wr_in_range = {1'b0, wr_addr}  < (ADDR_W+1)'(DEPTH);
    assign bus.err       = r_err;
`endif

    assign bus.ack   = r_ack;
    assign bus.busy  = r_busy;
    assign bus.rdata = r_rdata;

    // Array has no reset so preloaded contents survive rst_b.
    always_ff @(posedge clk) begin
`ifdef RESP_RANGE_CHECK_EN
        if (wr_en && w_wr_in_range) r_mem[wr_addr] <= wr_data;
`else
        if (wr_en) r_mem[wr_addr] <= wr_data;
`endif
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
            r_ack   <= 1'b0;
            r_busy  <= 1'b0;
            r_rdata <= '0;
`ifdef RESP_RANGE_CHECK_EN
            r_err   <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.req) begin
                        r_busy  <= 1'b1;
                        r_cnt   <= 4'(LATENCY - 1);
`ifdef RESP_RANGE_CHECK_EN
                        r_rdata <= w_rd_in_range ? r_mem[bus.addr] : '0;
                        r_err   <= !w_rd_in_range;
`else
                        r_rdata <= r_mem[bus.addr];
`endif
                        r_state <= (LATENCY == 1) ? S_ACK : S_WAIT;
                    end
                end
                S_WAIT: begin
                    r_cnt <= r_cnt - 4'd1;
                    if (r_cnt == 4'd1) r_state <= S_ACK;
                end
                S_ACK: begin
                    // First ACK cycle always raises ack, so an early req drop still gets one ack pulse.
                    if (!r_ack) begin
                        r_ack <= 1'b1;
                    end else if (!bus.req) begin
                        r_ack   <= 1'b0;
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: doc/weight_mem_responder.md
# weight_mem_responder

Responder end of the accelerator's req/ack memory fetch interface. It serves the controller's image-pixel, layer-1 weight and layer-2 weight fetches, with one instance per memory. Each instance holds a DEPTH-word array and answers each four-phase request with the addressed word after a fixed, parameterised latency. A separate write port preloads the array from the testbench or loader.

## Interface
Parameters:
- DATA_W, 32: read/write word width (four 8-bit operands per word).
- ADDR_W, 12: address width.
- DEPTH, 196: number of valid words; any value 1..2^ADDR_W, need not be a power of two.
- LATENCY, 2: cycles from request capture to ack assertion; legal range 1..15.

Ports:
- clk, input, 1: single clock; all logic is rising-edge.
- rst_b, input, 1: asynchronous active-low reset.
- req, input, 1: fetch request from controller; held high until ack is seen.
- addr, input, ADDR_W: fetch address; sampled only at capture.
- ack, output, 1: four-phase acknowledge.
- rdata, output, DATA_W: fetched word; valid whenever ack=1.
- busy, output, 1: high from capture until return to IDLE.
- wr_en, input, 1: array write strobe.
- wr_addr, input, ADDR_W: write address.
- wr_data, input, DATA_W: write data.
- err, output, 1: out-of-range flag (only when RESP_RANGE_CHECK_EN is defined).

## Operation
- FSM states: IDLE, WAIT, ACK.
- **IDLE:** if req=1 at a rising edge, it is a capture.
  - Latch addr.
  - Read the array word into a hold register; this is the read-at-capture value.
  - Load the latency counter with LATENCY-1.
  - busy goes to 1.
  - Next state is ACK if LATENCY=1, else WAIT.
- **WAIT:** decrement the counter each cycle. When the counter is 1, the next state is ACK. req is ignored in this state.
- **ACK:**
  - ack=1 and rdata = hold register.
  - Stay in ACK while req=1.
  - When req=0 is sampled: ack goes to 0 and busy goes to 0, then return to IDLE.
  - A new capture needs req=1 sampled in IDLE, so there is at least one cycle with req low between transactions.
- **rdata hold:** rdata keeps its last value after ack drops, until the next capture updates it.
- **Early req drop:** if req drops during WAIT (protocol violation), the transaction still completes. ack is high for exactly one cycle, then the FSM returns to IDLE.
- **Writes:**
  - Independent of the FSM; a write with wr_en=1 updates the array at the rising edge.
  - A write to the address being captured in the same cycle does not affect rdata: old data is returned (read-before-write).
  - Writes after capture never alter the pending rdata.
- **Address wrap:** the controller wraps at DEPTH itself. This block makes no address arithmetic beyond the range check.
- **Reset:** the array is not reset; its contents survive reset.

## Timing
- Reset values: ack=0, busy=0, rdata=0, err=0, state IDLE, counter 0.
- Reset mid-transaction aborts immediately; ack and busy are low asynchronously.
- Capture at edge N puts ack high after edge N+LATENCY.
- With the controller dropping req one cycle after it sees ack, ack falls after edge N+LATENCY+2.
- Back-to-back transactions take LATENCY+3 cycles each.
- All outputs are registered; there is no combinational path from req or addr to ack or rdata.
- The array read is synchronous at capture, so it maps to block RAM with a registered output.

## Configuration
- Macro: RESP_RANGE_CHECK_EN.
- **Defined:**
  - A capture with addr >= DEPTH loads rdata=0 and sets err=1.
  - err is valid alongside ack and holds until the next capture. The handshake is unchanged.
  - A write with wr_addr >= DEPTH is discarded.
- **Undefined:**
  - The err port is absent.
  - Out-of-range read and write addresses are used modulo 2^ADDR_W on the physical array, which is sized 2^ADDR_W.
  - Data returned for addresses >= DEPTH is unspecified.

## Test plan
- **Basic read:** preload word 5 = 0xA1B2C3D4, LATENCY=2, assert req with addr=5 → ack rises 2 cycles after capture with rdata=0xA1B2C3D4, busy=1 throughout. Drop req → ack=0 and busy=0 next cycle.
- **Latency sweep and back-to-back:** with LATENCY=1 and LATENCY=15, run 196 sequential reads at addr 0..195 with the controller-style req drop → every rdata matches its preload, and each transaction lasts LATENCY+3 cycles.
- **Read-before-write collision:** capture addr=7 (old 0x11111111) while wr_en writes 0x22222222 to addr 7 in the same cycle → rdata=0x11111111. A subsequent read of addr 7 → 0x22222222.
- **Early req drop:** req high for 1 cycle only, LATENCY=4 → ack high for exactly 1 cycle after edge N+4, then IDLE, and no second capture.
- **Reset mid-transaction:** pulse rst_b low during WAIT → ack=0, busy=0 and rdata=0 immediately. After release, reading the preloaded word 3 → correct data, since array contents are retained.
- **Range check (macro defined):** DEPTH=196, read addr=196 → ack with rdata=0 and err=1. Write to addr 200 is ignored. A following read of addr=0 → err=0.
